// File: rtl/fb_seq_pkg.sv
// Shared types and defaults for the frame-buffer write sequencer.
// Contents:
//   FB_ADDR_W / FB_DATA_W  default frame-buffer address and colour-index widths
//   seq_state_e            sequencer FSM states
//   sel_width()            width of a select/counter for n values, never below 1
package fb_seq_pkg;

    localparam int unsigned FB_ADDR_W = 19;
    localparam int unsigned FB_DATA_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StIssue,
        StWait,
        StNext,
        StDone
    } seq_state_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_wport_mux.sv
// Combinational NUM_CH:1 select of the engines' write buses, with optional
// per-channel colour override. The caller registers the result.
// Ports:
//   sel       active channel number
//   waddr     packed engine write addresses, channel c at [c*ADDR_W +: ADDR_W]
//   wdata     packed engine write data
//   wenable   engine write enables
//   color_en  1 = replace that channel's data with its colour
//   color     packed per-channel override colours
//   addr/data/en  selected write bus
module fb_wport_mux
    import fb_seq_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W
) (
    input  logic [sel_width(NUM_CH)-1:0] sel,
    input  logic [NUM_CH*ADDR_W-1:0]     waddr,
    input  logic [NUM_CH*DATA_W-1:0]     wdata,
    input  logic [NUM_CH-1:0]            wenable,
    input  logic [NUM_CH-1:0]            color_en,
    input  logic [NUM_CH*DATA_W-1:0]     color,
    output logic [ADDR_W-1:0]            addr,
    output logic [DATA_W-1:0]            data,
    output logic                         en
);

    localparam int unsigned CH_W = sel_width(NUM_CH);

    always_comb begin
        addr = '0;
        data = '0;
        en   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel == CH_W'(c)) begin
                addr = waddr[c*ADDR_W +: ADDR_W];
                data = color_en[c] ? color[c*DATA_W +: DATA_W] : wdata[c*DATA_W +: DATA_W];
                en   = wenable[c];
            end
        end
    end

endmodule

// File: rtl/fb_write_sequencer.sv
// Time-multiplexes one frame-buffer write port among NUM_CH drawing engines.
// Channels are walked 0..NUM_CH-1; each gets ch_count[c] items issued one at a
// time over a start/finish handshake, and the active engine's writes are
// forwarded (registered) to the pixel memory.
// Ports:
//   clock, resetn            clock (rising edge), async active-low reset
//   continuous               restart at channel 0 after the last channel
//   frame_start              one-cycle trigger, honoured only when idle
//   ch_count                 items per channel, latched at frame start
//   ch_color_en / ch_color   per-channel colour override
//   ch_start / ch_index      one-hot start pulse and item index to the engine
//   ch_sel                   active channel (0 when idle)
//   ch_finish                engine done with current item
//   ch_waddr/wdata/wenable   engine write buses
//   mem_waddr/wdata/wenable  registered frame-buffer write port
//   busy, frame_done, timeout_err  status
module fb_write_sequencer
    import fb_seq_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ADDR_W  = FB_ADDR_W,
    parameter int unsigned DATA_W  = FB_DATA_W,
    parameter int unsigned IDX_W   = 9,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         continuous,
    input  logic                         frame_start,
    input  logic [NUM_CH*IDX_W-1:0]      ch_count,
    input  logic [NUM_CH-1:0]            ch_color_en,
    input  logic [NUM_CH*DATA_W-1:0]     ch_color,
    output logic [NUM_CH-1:0]            ch_start,
    output logic [IDX_W-1:0]             ch_index,
    output logic [sel_width(NUM_CH)-1:0] ch_sel,
    input  logic [NUM_CH-1:0]            ch_finish,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_waddr,
    input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
    input  logic [NUM_CH-1:0]            ch_wenable,
    output logic [ADDR_W-1:0]            mem_waddr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic                         mem_wenable,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         timeout_err
);

    localparam int unsigned CH_W   = sel_width(NUM_CH);
    localparam int unsigned WDOG_W = sel_width(TIMEOUT);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = (TIMEOUT == 0) ? '0 : WDOG_W'(TIMEOUT - 1);

    seq_state_e        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  count_q [NUM_CH];
    logic              latch;

    logic [IDX_W-1:0]  cur_count;
    logic              cur_finish;
    logic [NUM_CH-1:0] ch_onehot;
    logic [IDX_W:0]    idx_inc;
    logic              wdog_expire;

    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_data;
    logic              mux_en;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_wenable_q;

    // Per-channel views of the active channel.
    always_comb begin
        cur_count  = '0;
        cur_finish = 1'b0;
        ch_onehot  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
                cur_count    = count_q[c];
                cur_finish   = ch_finish[c];
                ch_onehot[c] = 1'b1;
            end
        end
    end

    // One extra bit so idx+1 never wraps before the compare.
    assign idx_inc     = {1'b0, idx_q} + 1'b1;
    assign wdog_expire = (TIMEOUT != 0) && (wdog_q == WDOG_MAX);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        latch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    latch   = 1'b1;
                    err_d   = 1'b0;
                    ch_d    = '0;
                    idx_d   = '0;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if (cur_count == '0) begin
                    if (ch_q == LAST_CH) state_d = StDone;
                    else                 ch_d    = ch_q + 1'b1;
                end else begin
                    wdog_d  = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // Finish is only looked at here, so a held finish cannot count twice.
                if (cur_finish) begin
                    state_d = StNext;
                end else if (wdog_expire) begin
                    err_d   = 1'b1;
                    state_d = StNext;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StNext: begin
                if (idx_inc < {1'b0, cur_count}) begin
                    idx_d   = idx_q + 1'b1;
                    wdog_d  = '0;
                    state_d = StIssue;
                end else begin
                    idx_d = '0;
                    if (ch_q == LAST_CH) begin
                        state_d = StDone;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = StSelect;
                    end
                end
            end
            StDone: begin
                ch_d  = '0;
                idx_d = '0;
                if (continuous) begin
                    latch   = 1'b1;
                    state_d = StSelect;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            ch_q    <= '0;
            idx_q   <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) count_q[c] <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
            if (latch) begin
                for (int c = 0; c < NUM_CH; c++) count_q[c] <= ch_count[c*IDX_W +: IDX_W];
            end
        end
    end

    fb_wport_mux #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .sel      (ch_q),
        .waddr    (ch_waddr),
        .wdata    (ch_wdata),
        .wenable  (ch_wenable),
        .color_en (ch_color_en),
        .color    (ch_color),
        .addr     (mux_addr),
        .data     (mux_data),
        .en       (mux_en)
    );

    // Writes are suppressed in the finish cycle: the engine may already have
    // released its bus.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_waddr_q   <= '0;
            mem_wdata_q   <= '0;
            mem_wenable_q <= 1'b0;
        end else if (state_q == StIssue || state_q == StWait) begin
            mem_waddr_q   <= mux_addr;
            mem_wdata_q   <= mux_data;
            mem_wenable_q <= mux_en && !(state_q == StWait && cur_finish);
        end else begin
            mem_wenable_q <= 1'b0;
        end
    end

    assign ch_start    = (state_q == StIssue) ? ch_onehot : '0;
    assign ch_index    = idx_q;
    assign ch_sel      = ch_q;
    assign mem_waddr   = mem_waddr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wenable = mem_wenable_q;
    assign busy        = (state_q != StIdle);
    assign frame_done  = (state_q == StDone);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_fb_write_sequencer.sv
// Directed bench for fb_write_sequencer: two channels, watchdog of 16 cycles,
// behavioural engines that finish a fixed number of cycles after start.
module tb_fb_write_sequencer;

    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned DATA_W  = 3;
    localparam int unsigned IDX_W   = 9;
    localparam int unsigned TIMEOUT = 16;

    logic                     clock = 1'b0;
    logic                     resetn;
    logic                     continuous;
    logic                     frame_start;
    logic [NUM_CH*IDX_W-1:0]  ch_count;
    logic [NUM_CH-1:0]        ch_color_en;
    logic [NUM_CH*DATA_W-1:0] ch_color;
    logic [NUM_CH-1:0]        ch_start;
    logic [IDX_W-1:0]         ch_index;
    logic [0:0]               ch_sel;
    logic [NUM_CH-1:0]        ch_finish;
    logic [NUM_CH*ADDR_W-1:0] ch_waddr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_wenable;
    logic [ADDR_W-1:0]        mem_waddr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_wenable;
    logic                     busy;
    logic                     frame_done;
    logic                     timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    fb_write_sequencer #(
        .NUM_CH  (NUM_CH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .continuous  (continuous),
        .frame_start (frame_start),
        .ch_count    (ch_count),
        .ch_color_en (ch_color_en),
        .ch_color    (ch_color),
        .ch_start    (ch_start),
        .ch_index    (ch_index),
        .ch_sel      (ch_sel),
        .ch_finish   (ch_finish),
        .ch_waddr    (ch_waddr),
        .ch_wdata    (ch_wdata),
        .ch_wenable  (ch_wenable),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_wenable (mem_wenable),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    // Engine model: finish rises fin_delay WAIT cycles after the start pulse,
    // unless the item index equals hang_idx; tie_high forces finish high.
    int          fin_delay = 5;
    int          hang_idx  = -1;
    logic        tie_high  = 1'b0;
    logic [NUM_CH-1:0] eng_busy;
    int          eng_cnt [NUM_CH];
    int          eng_idx [NUM_CH];

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            eng_busy <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                eng_cnt[c] <= 0;
                eng_idx[c] <= 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_start[c]) begin
                    eng_busy[c] <= 1'b1;
                    eng_cnt[c]  <= 1;
                    eng_idx[c]  <= int'(ch_index);
                end else if (eng_busy[c]) begin
                    if (ch_finish[c]) eng_busy[c] <= 1'b0;
                    else              eng_cnt[c]  <= eng_cnt[c] + 1;
                end
            end
        end
    end

    always_comb begin
        ch_finish = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_finish[c] = tie_high ||
                (eng_busy[c] && eng_cnt[c] == fin_delay && eng_idx[c] != hang_idx);
        end
    end

    // Activity log: start pulses and frame_done cycles, time-stamped.
    int cyc = 0;
    int start_ch [$];
    int start_idx [$];
    int start_t [$];
    int done_t [$];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (resetn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_start[c]) begin
                    start_ch.push_back(c);
                    start_idx.push_back(int'(ch_index));
                    start_t.push_back(cyc);
                end
            end
            if (frame_done) done_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        start_ch.delete();
        start_idx.delete();
        start_t.delete();
        done_t.delete();
    endtask

    task automatic start_frame(input int c0, input int c1);
        ch_count    = {IDX_W'(c1), IDX_W'(c0)};
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!frame_done && n < budget) begin
            tick();
            n++;
        end
        check(tag, frame_done, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        resetn      = 1'b0;
        continuous  = 1'b0;
        frame_start = 1'b0;
        ch_count    = '0;
        ch_color_en = '0;
        ch_color    = '0;
        ch_waddr    = '0;
        ch_wdata    = '0;
        ch_wenable  = '0;
        tick();
        tick();

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_start", ch_start, 0);
        check("rst_sel", ch_sel, 0);
        check("rst_index", ch_index, 0);
        check("rst_mem_we", mem_wenable, 0);
        check("rst_mem_addr", mem_waddr, 0);
        check("rst_done", frame_done, 0);
        check("rst_terr", timeout_err, 0);
        resetn = 1'b1;
        tick();

        // T1: counts {3,2}, finish 5 cycles after start.
        clear_log();
        start_frame(3, 2);
        check("t1_busy", busy, 1);
        wait_done(200, "t1_done_seen");
        check("t1_idle", busy, 0);
        check("t1_nstarts", start_ch.size(), 5);
        check("t1_ndone", done_t.size(), 1);
        if (start_ch.size() == 5) begin
            check("t1_s0", start_ch[0] * 1000 + start_idx[0], 0);
            check("t1_s1", start_ch[1] * 1000 + start_idx[1], 1);
            check("t1_s2", start_ch[2] * 1000 + start_idx[2], 2);
            check("t1_s3", start_ch[3] * 1000 + start_idx[3], 1000);
            check("t1_s4", start_ch[4] * 1000 + start_idx[4], 1001);
            check("t1_gap", start_t[1] - start_t[0], 7);
        end

        // T2a: ch0 empty, ch1 gets 4 items.
        clear_log();
        start_frame(0, 4);
        wait_done(200, "t2a_done_seen");
        check("t2a_nstarts", start_ch.size(), 4);
        for (int i = 0; i < start_ch.size(); i++) begin
            check("t2a_ch", start_ch[i], 1);
            check("t2a_idx", start_idx[i], i);
        end

        // T2b: both empty -> frame_done 3 cycles after frame_start.
        clear_log();
        ch_count    = '0;
        frame_start = 1'b1;
        n = 0;
        do begin
            tick();
            frame_start = 1'b0;
            n++;
        end while (!frame_done && n < 20);
        check("t2b_latency", n, 3);
        tick();
        check("t2b_nstarts", start_ch.size(), 0);

        // T3: colour override on ch1 and 1-cycle write latency.
        clear_log();
        ch_color_en = 2'b10;
        ch_color    = {3'b010, 3'b110};
        ch_wdata    = {3'b111, 3'b101};
        ch_waddr    = {19'h01234, 19'h07777};
        ch_wenable  = 2'b10;
        start_frame(0, 1);
        n = 0;
        while (!ch_start[1] && n < 50) begin
            tick();
            n++;
        end
        check("t3_start_seen", ch_start[1], 1);
        tick();
        check("t3_wdata", mem_wdata, 3'b010);
        check("t3_waddr", mem_waddr, 19'h01234);
        check("t3_we", mem_wenable, 1);
        ch_waddr = {19'h00abc, 19'h07777};
        check("t3_waddr_lag", mem_waddr, 19'h01234);
        tick();
        check("t3_waddr_next", mem_waddr, 19'h00abc);
        wait_done(100, "t3_done_seen");
        check("t3_we_after", mem_wenable, 0);
        check("t3_waddr_hold", mem_waddr, 19'h00abc);
        ch_wenable  = '0;
        ch_color_en = '0;

        // T4: item 1 of 3 never finishes -> skipped by the watchdog.
        clear_log();
        hang_idx = 1;
        start_frame(3, 0);
        wait_done(300, "t4_done_seen");
        check("t4_terr", timeout_err, 1);
        check("t4_nstarts", start_ch.size(), 3);
        if (start_ch.size() == 3) begin
            check("t4_idx2", start_idx[2], 2);
            check("t4_skip_gap", start_t[2] - start_t[1], 18);
        end
        hang_idx = -1;
        start_frame(1, 0);
        check("t4_terr_clr", timeout_err, 0);
        wait_done(100, "t4b_done_seen");

        // T5: continuous with finish tied high.
        clear_log();
        tie_high   = 1'b1;
        continuous = 1'b1;
        start_frame(1, 1);
        n = 0;
        while (done_t.size() < 3 && n < 200) begin
            tick();
            n++;
        end
        continuous = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("t5_idle", busy, 0);
        check("t5_one_start_per_item", start_ch.size(), 2 * done_t.size());
        if (done_t.size() >= 3 && start_ch.size() >= 4) begin
            check("t5_period0", done_t[1] - done_t[0], 9);
            check("t5_period1", done_t[2] - done_t[1], 9);
            check("t5_ch_seq", start_ch[0] * 8 + start_ch[1] * 4 + start_ch[2] * 2 + start_ch[3], 5);
            check("t5_gap01", start_t[1] - start_t[0], 4);
            check("t5_gap12", start_t[2] - start_t[1], 5);
        end else begin
            check("t5_enough_frames", 0, 1);
        end
        tie_high = 1'b0;
        tick();

        // T6: asynchronous reset in the middle of WAIT.
        clear_log();
        start_frame(3, 0);
        n = 0;
        while (start_ch.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        check("t6_reached_item1", start_ch.size(), 2);
        ch_waddr   = {19'h00000, 19'h00155};
        ch_wenable = 2'b01;
        tick();
        check("t6_pre_we", mem_wenable, 1);
        check("t6_pre_index", ch_index, 1);
        #3;
        resetn = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_index", ch_index, 0);
        check("t6_start", ch_start, 0);
        check("t6_we", mem_wenable, 0);
        check("t6_waddr", mem_waddr, 0);
        check("t6_terr", timeout_err, 0);
        ch_wenable = '0;
        tick();
        tick();
        resetn = 1'b1;
        clear_log();
        for (int i = 0; i < 20; i++) tick();
        check("t6_quiet_starts", start_ch.size(), 0);
        check("t6_quiet_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
